// File: rtl/mcash_pkg.sv
// Shared definitions for the mcash request front end: op codes, address width
// and the default-width request record.
package mcash_pkg;

   localparam int         MCASH_OP_W     = 3;
   localparam int         MCASH_ADDR_W   = 28;
   localparam int         MCASH_DATA_W   = 128;
   localparam logic [2:0] MCASH_OP_READ  = 3'b000;
   localparam logic [2:0] MCASH_OP_WRITE = 3'b001;

   // Request record at the default data width; the arbiter re-declares it
   // with its own DATA_W and CH_ID_W.
   typedef struct packed {
      logic [MCASH_OP_W-1:0]   op;
      logic [MCASH_ADDR_W-1:0] addr;
      logic [MCASH_DATA_W-1:0] data;
      logic [1:0]              chid;
   } mcash_req_t;

endpackage

// File: rtl/mcash_chn_arb_if.sv
// Channel-side and pipeline-side bus of the mcash channel arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mcash_chn_arb_if
   import mcash_pkg::*;
#(
   parameter int CH_NUM  = 3,
   parameter int DATA_W  = 128,
   parameter int CH_ID_W = $clog2(CH_NUM)
);
   logic [CH_NUM-1:0]              ch_req_valid_i;
   logic [CH_NUM-1:0]              ch_req_allowIn_o;
   logic [CH_NUM*MCASH_OP_W-1:0]   ch_req_op_i;
   logic [CH_NUM*MCASH_ADDR_W-1:0] ch_req_addr_i;
   logic [CH_NUM*DATA_W-1:0]       ch_req_data_i;
   logic [CH_NUM-1:0]              ch_rtn_valid_o;
   logic [CH_NUM-1:0]              ch_rtn_ready_i;
   logic [CH_NUM*DATA_W-1:0]       ch_rtn_data_o;
   logic                           pipe_req_valid_o;
   logic                           pipe_req_allowIn_i;
   logic [MCASH_OP_W-1:0]          pipe_req_op_o;
   logic [MCASH_ADDR_W-1:0]        pipe_req_addr_o;
   logic [DATA_W-1:0]              pipe_req_data_o;
   logic [CH_ID_W-1:0]             pipe_req_chid_o;
   logic                           pipe_rtn_valid_i;
   logic [CH_ID_W-1:0]             pipe_rtn_chid_i;
   logic [DATA_W-1:0]              pipe_rtn_data_i;
   logic                           pipe_rtn_ready_o;

   modport slave (
      input  ch_req_valid_i, ch_req_op_i, ch_req_addr_i, ch_req_data_i, ch_rtn_ready_i,
      input  pipe_req_allowIn_i, pipe_rtn_valid_i, pipe_rtn_chid_i, pipe_rtn_data_i,
      output ch_req_allowIn_o, ch_rtn_valid_o, ch_rtn_data_o,
      output pipe_req_valid_o, pipe_req_op_o, pipe_req_addr_o, pipe_req_data_o,
      output pipe_req_chid_o, pipe_rtn_ready_o
   );

   modport master (
      output ch_req_valid_i, ch_req_op_i, ch_req_addr_i, ch_req_data_i, ch_rtn_ready_i,
      output pipe_req_allowIn_i, pipe_rtn_valid_i, pipe_rtn_chid_i, pipe_rtn_data_i,
      input  ch_req_allowIn_o, ch_rtn_valid_o, ch_rtn_data_o,
      input  pipe_req_valid_o, pipe_req_op_o, pipe_req_addr_o, pipe_req_data_o,
      input  pipe_req_chid_o, pipe_rtn_ready_o
   );

endinterface

// File: rtl/mcash_rtn_fifo.sv
// Per-channel read-return FIFO. Full/empty are told apart by a pointer wrap
// bit; a push into a full FIFO is accepted only when a pop frees a slot in
// the same cycle, otherwise the data is dropped. Head data reads as 0 when empty.
module mcash_rtn_fifo #(
   parameter int DATA_W    = 128,
   parameter int RTN_DEPTH = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic              valid_o,
   output logic              full_o,
   output logic [DATA_W-1:0] data_o
);
   localparam int AW = $clog2(RTN_DEPTH);

   logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [RTN_DEPTH];
   logic              empty, push_ok, pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ok  = pop_i & ~empty;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign valid_o = ~empty;
   assign data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance on accepted push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q + (push_ok ? (AW+1)'(1) : '0);
      rd_ptr_d = rd_ptr_q + (pop_ok  ? (AW+1)'(1) : '0);
   end

   // Pointer registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/mcash_chn_arb.sv
// mcash_chn_arb: round-robin merge of CH_NUM request channels onto one
// pipeline request port, with credit-protected per-channel return FIFOs.
// Optional macro MCASH_ARB_OUTREG_EN: register the pipeline request in a
// one-entry slice (1-cycle latency, full throughput); otherwise the request
// is a combinational mux of the granted channel.
module mcash_chn_arb
   import mcash_pkg::*;
#(
   parameter int CH_NUM    = 3,
   parameter int DATA_W    = 128,
   parameter int RTN_DEPTH = 2
) (
   input logic            clk_i,
   input logic            rst_i,
   mcash_chn_arb_if.slave bus
);
   localparam int CH_ID_W = $clog2(CH_NUM);
   localparam int CRD_W   = $clog2(RTN_DEPTH) + 1;

   typedef struct packed {
      logic [MCASH_OP_W-1:0]   op;
      logic [MCASH_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]       data;
      logic [CH_ID_W-1:0]      chid;
   } req_t;

   logic [CH_NUM-1:0]             is_read, elig, gnt_oh, pop, push, rtn_vld, rtn_full;
   logic [CH_NUM-1:0][DATA_W-1:0] rtn_data;
   logic                          gnt_vld, can_accept, xfer;
   logic [CH_ID_W-1:0]            gnt_id, rr_ptr_q, rr_ptr_d;
   logic [CRD_W-1:0]              credit_q [CH_NUM];
   logic [CRD_W-1:0]              credit_d [CH_NUM];
   req_t                          gnt_req;

   // Eligibility: a READ needs a free return slot; nothing is eligible in reset.
   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         is_read[i] = (bus.ch_req_op_i[MCASH_OP_W*i +: MCASH_OP_W] == MCASH_OP_READ);
         elig[i]    = ~rst_i & bus.ch_req_valid_i[i] &
                      (~is_read[i] | (credit_q[i] < CRD_W'(RTN_DEPTH)));
      end
   end

   // Round-robin pick: first eligible channel at or after rr_ptr (lowest offset wins).
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      for (int k = CH_NUM - 1; k >= 0; k--) begin
         int idx;
         idx = int'(rr_ptr_q) + k;
         if (idx >= CH_NUM) idx = idx - CH_NUM;
         if (elig[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = CH_ID_W'(idx);
         end
      end
   end

   // Granted channel's request, zero when nothing is granted.
   always_comb begin
      gnt_req = '0;
      gnt_oh  = '0;
      if (gnt_vld) begin
         gnt_oh[gnt_id] = 1'b1;
         gnt_req.op     = bus.ch_req_op_i[MCASH_OP_W*int'(gnt_id) +: MCASH_OP_W];
         gnt_req.addr   = bus.ch_req_addr_i[MCASH_ADDR_W*int'(gnt_id) +: MCASH_ADDR_W];
         gnt_req.data   = bus.ch_req_data_i[DATA_W*int'(gnt_id) +: DATA_W];
         gnt_req.chid   = gnt_id;
      end
   end

`ifdef MCASH_ARB_OUTREG_EN
   logic slice_vld_q, slice_vld_d;
   req_t slice_q, slice_d;

   assign can_accept = ~slice_vld_q | bus.pipe_req_allowIn_i;

   // Slice loads on a transfer, drains when the pipeline takes it with nothing new.
   always_comb begin
      slice_vld_d = slice_vld_q;
      slice_d     = slice_q;
      if (xfer) begin
         slice_vld_d = 1'b1;
         slice_d     = gnt_req;
      end else if (bus.pipe_req_allowIn_i) begin
         slice_vld_d = 1'b0;
      end
   end

   // Output slice registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slice_vld_q <= 1'b0;
         slice_q     <= '0;
      end else begin
         slice_vld_q <= slice_vld_d;
         slice_q     <= slice_d;
      end
   end

   assign bus.pipe_req_valid_o = slice_vld_q;
   assign bus.pipe_req_op_o    = slice_q.op;
   assign bus.pipe_req_addr_o  = slice_q.addr;
   assign bus.pipe_req_data_o  = slice_q.data;
   assign bus.pipe_req_chid_o  = slice_q.chid;
`else
   assign can_accept           = bus.pipe_req_allowIn_i;
   assign bus.pipe_req_valid_o = gnt_vld;
   assign bus.pipe_req_op_o    = gnt_req.op;
   assign bus.pipe_req_addr_o  = gnt_req.addr;
   assign bus.pipe_req_data_o  = gnt_req.data;
   assign bus.pipe_req_chid_o  = gnt_req.chid;
`endif

   assign xfer                 = gnt_vld & can_accept;
   assign bus.ch_req_allowIn_o = xfer ? gnt_oh : '0;
   assign bus.pipe_rtn_ready_o = ~rst_i;

   // Pointer moves past the winner only when a transfer happens.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer) rr_ptr_d = (gnt_id == CH_ID_W'(CH_NUM - 1)) ? '0 : gnt_id + CH_ID_W'(1);
   end

   // Credit: +1 per READ issued, -1 per return popped; never wraps below 0.
   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         credit_d[i] = credit_q[i];
         if ((xfer & gnt_oh[i] & is_read[i]) && !(pop[i] && credit_q[i] != '0))
            credit_d[i] = credit_q[i] + CRD_W'(1);
         else if (!(xfer & gnt_oh[i] & is_read[i]) && pop[i] && credit_q[i] != '0)
            credit_d[i] = credit_q[i] - CRD_W'(1);
      end
   end

   // Arbiter pointer and credit registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         for (int i = 0; i < CH_NUM; i++) credit_q[i] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int i = 0; i < CH_NUM; i++) credit_q[i] <= credit_d[i];
      end
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_rtn
      assign push[g] = bus.pipe_rtn_valid_i & (bus.pipe_rtn_chid_i == CH_ID_W'(g));
      assign pop[g]  = rtn_vld[g] & bus.ch_rtn_ready_i[g];

      mcash_rtn_fifo #(.DATA_W(DATA_W), .RTN_DEPTH(RTN_DEPTH)) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (push[g]),
         .data_i  (bus.pipe_rtn_data_i),
         .pop_i   (bus.ch_rtn_ready_i[g]),
         .valid_o (rtn_vld[g]),
         .full_o  (rtn_full[g]),
         .data_o  (rtn_data[g])
      );
   end

   assign bus.ch_rtn_valid_o = rtn_vld;
   assign bus.ch_rtn_data_o  = rtn_data;

   // Return protocol: chid must name a channel, and a full FIFO only takes a push alongside a pop.
   a_rtn_chid : assert property (@(posedge clk_i) disable iff (rst_i)
      bus.pipe_rtn_valid_i |-> (int'(bus.pipe_rtn_chid_i) < CH_NUM));
   a_rtn_ovf : assert property (@(posedge clk_i) disable iff (rst_i)
      (push & rtn_full & ~pop) == '0);

endmodule
